mem_bus_arbiter: RTL

//  Shares one AXI4-Lite style master port between instruction fetch (read-only) and the
//  EX-stage load/store request (rd/wr enables, address, write data, byte strobes).
//  One outstanding transaction at a time. Data side has priority; a starvation guard

---
 rtl/mem_bus_arbiter.sv | 257 +++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_bus_arbiter: fetch / load-store arbiter onto one AXI4-Lite master port  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mem_bus_arbiter #(
    parameter int ADDR_W       = 64,
    parameter int DATA_W       = 64,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    // instruction fetch requester
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_ack,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_err,
    // EX-stage load/store requester
    input  logic                mem_rd_en,
    input  logic [ADDR_W-1:0]   addr_mem_rd,
    input  logic                mem_wr_en,
    input  logic [ADDR_W-1:0]   addr_mem_wr,
    input  logic [DATA_W-1:0]   data_mem_wr,
    input  logic [DATA_W/8-1:0] strb_mem_wr,
    input  logic                mem_except,
    output logic                mem_ack,
    output logic [DATA_W-1:0]   mem_rdata,
    output logic                mem_err,
    output logic                busy,
    // AXI4-Lite read channels
    output logic [ADDR_W-1:0]   araddr,
    output logic                arvalid,
    input  logic                arready,
    input  logic [DATA_W-1:0]   rdata,
    input  logic [1:0]          rresp,
    input  logic                rvalid,
    output logic                rready,
    // AXI4-Lite write channels
    output logic [ADDR_W-1:0]   awaddr,
    output logic                awvalid,
    input  logic                awready,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic                wvalid,
    input  logic                wready,
    input  logic [1:0]          bresp,
    input  logic                bvalid,
    output logic                bready
);

    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_ADDR = 3'd1,
        S_RD_DATA = 3'd2,
        S_WR_ADDR = 3'd3,
        S_WR_RESP = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_starve_cnt;
    logic                r_owner_if;
    logic [ADDR_W-1:0]   r_araddr;
    logic                r_arvalid;
    logic                r_rready;
    logic [ADDR_W-1:0]   r_awaddr;
    logic                r_awvalid;
    logic [DATA_W-1:0]   r_wdata;
    logic [STRB_W-1:0]   r_wstrb;
    logic                r_wvalid;
    logic                r_bready;
    logic [DATA_W-1:0]   r_if_rdata;
    logic                r_if_err;
    logic [DATA_W-1:0]   r_mem_rdata;
    logic                r_mem_err;

    state_t              w_nxt_state;
    logic [CNT_W-1:0]    w_nxt_starve_cnt;
    logic                w_nxt_owner_if;
    logic [ADDR_W-1:0]   w_nxt_araddr;
    logic                w_nxt_arvalid;
    logic                w_nxt_rready;
    logic [ADDR_W-1:0]   w_nxt_awaddr;
    logic                w_nxt_awvalid;
    logic [DATA_W-1:0]   w_nxt_wdata;
    logic [STRB_W-1:0]   w_nxt_wstrb;
    logic                w_nxt_wvalid;
    logic                w_nxt_bready;
    logic [DATA_W-1:0]   w_nxt_if_rdata;
    logic                w_nxt_if_err;
    logic [DATA_W-1:0]   w_nxt_mem_rdata;
    logic                w_nxt_mem_err;

    logic                w_data_req;
    logic                w_starved;
    logic                w_aw_done;
    logic                w_w_done;

    assign w_data_req = (mem_rd_en | mem_wr_en) & ~mem_except;
    assign w_starved  = if_req & (r_starve_cnt == CNT_W'(STARVE_LIMIT));
    // A write channel counts as done once its valid has dropped or it handshakes now.
    assign w_aw_done  = ~r_awvalid | awready;
    assign w_w_done   = ~r_wvalid  | wready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_starve_cnt <= '0;
            r_owner_if   <= 1'b0;
            r_araddr     <= '0;
            r_arvalid    <= 1'b0;
            r_rready     <= 1'b0;
            r_awaddr     <= '0;
            r_awvalid    <= 1'b0;
            r_wdata      <= '0;
            r_wstrb      <= '0;
            r_wvalid     <= 1'b0;
            r_bready     <= 1'b0;
            r_if_rdata   <= '0;
            r_if_err     <= 1'b0;
            r_mem_rdata  <= '0;
            r_mem_err    <= 1'b0;
        end else begin
            r_state      <= w_nxt_state;
            r_starve_cnt <= w_nxt_starve_cnt;
            r_owner_if   <= w_nxt_owner_if;
            r_araddr     <= w_nxt_araddr;
            r_arvalid    <= w_nxt_arvalid;
            r_rready     <= w_nxt_rready;
            r_awaddr     <= w_nxt_awaddr;
            r_awvalid    <= w_nxt_awvalid;
            r_wdata      <= w_nxt_wdata;
            r_wstrb      <= w_nxt_wstrb;
            r_wvalid     <= w_nxt_wvalid;
            r_bready     <= w_nxt_bready;
            r_if_rdata   <= w_nxt_if_rdata;
            r_if_err     <= w_nxt_if_err;
            r_mem_rdata  <= w_nxt_mem_rdata;
            r_mem_err    <= w_nxt_mem_err;
        end
    end

    always_comb begin
        w_nxt_state      = r_state;
        w_nxt_starve_cnt = r_starve_cnt;
        w_nxt_owner_if   = r_owner_if;
        w_nxt_araddr     = r_araddr;
        w_nxt_arvalid    = r_arvalid;
        w_nxt_rready     = r_rready;
        w_nxt_awaddr     = r_awaddr;
        w_nxt_awvalid    = r_awvalid;
        w_nxt_wdata      = r_wdata;
        w_nxt_wstrb      = r_wstrb;
        w_nxt_wvalid     = r_wvalid;
        w_nxt_bready     = r_bready;
        w_nxt_if_rdata   = r_if_rdata;
        w_nxt_if_err     = r_if_err;
        w_nxt_mem_rdata  = r_mem_rdata;
        w_nxt_mem_err    = r_mem_err;

        case (r_state)
            S_IDLE: begin
                if (w_starved || (!w_data_req && if_req)) begin
                    w_nxt_owner_if   = 1'b1;
                    w_nxt_starve_cnt = '0;
                    w_nxt_araddr     = if_addr;
                    w_nxt_arvalid    = 1'b1;
                    w_nxt_state      = S_RD_ADDR;
                end else if (w_data_req) begin
                    w_nxt_owner_if   = 1'b0;
                    w_nxt_starve_cnt = if_req ? (r_starve_cnt + CNT_W'(1)) : '0;
                    // Store wins when both enables are high.
                    if (mem_wr_en) begin
                        w_nxt_awaddr  = addr_mem_wr;
                        w_nxt_wdata   = data_mem_wr;
                        w_nxt_wstrb   = strb_mem_wr;
                        w_nxt_awvalid = 1'b1;
                        w_nxt_wvalid  = 1'b1;
                        w_nxt_state   = S_WR_ADDR;
                    end else begin
                        w_nxt_araddr  = addr_mem_rd;
                        w_nxt_arvalid = 1'b1;
                        w_nxt_state   = S_RD_ADDR;
                    end
                end
            end
            S_RD_ADDR: begin
                if (arready) begin
                    w_nxt_arvalid = 1'b0;
                    w_nxt_rready  = 1'b1;
                    w_nxt_state   = S_RD_DATA;
                end
            end
            S_RD_DATA: begin
                if (rvalid) begin
                    w_nxt_rready = 1'b0;
                    if (r_owner_if) begin
                        w_nxt_if_rdata = rdata;
                        w_nxt_if_err   = |rresp;
                    end else begin
                        w_nxt_mem_rdata = rdata;
                        w_nxt_mem_err   = |rresp;
                    end
                    w_nxt_state = S_DONE;
                end
            end
            S_WR_ADDR: begin
                if (r_awvalid && awready) begin
                    w_nxt_awvalid = 1'b0;
                end
                if (r_wvalid && wready) begin
                    w_nxt_wvalid = 1'b0;
                end
                if (w_aw_done && w_w_done) begin
                    w_nxt_bready = 1'b1;
                    w_nxt_state  = S_WR_RESP;
                end
            end
            S_WR_RESP: begin
                if (bvalid) begin
                    w_nxt_bready  = 1'b0;
                    w_nxt_mem_err = |bresp;
                    w_nxt_state   = S_DONE;
                end
            end
            S_DONE: begin
                w_nxt_state = S_IDLE;
            end
            default: begin
                w_nxt_state = S_IDLE;
            end
        endcase
    end

    assign if_ack    = (r_state == S_DONE) &  r_owner_if;
    assign mem_ack   = (r_state == S_DONE) & ~r_owner_if;
    assign busy      = (r_state != S_IDLE);
    assign if_rdata  = r_if_rdata;
    assign if_err    = r_if_err;
    assign mem_rdata = r_mem_rdata;
    assign mem_err   = r_mem_err;
    assign araddr    = r_araddr;
    assign arvalid   = r_arvalid;
    assign rready    = r_rready;
    assign awaddr    = r_awaddr;
    assign awvalid   = r_awvalid;
    assign wdata     = r_wdata;
    assign wstrb     = r_wstrb;
    assign wvalid    = r_wvalid;
    assign bready    = r_bready;

endmodule
`default_nettype wire
